// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the TinyMIPS multicycle controller: FSM states,
// opcode/funct fields and the ALU control codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH1  = 4'd0,
        FETCH2  = 4'd1,
        FETCH3  = 4'd2,
        FETCH4  = 4'd3,
        DECODE  = 4'd4,
        MEMADR  = 4'd5,
        LBRD    = 4'd6,
        LBWR    = 4'd7,
        SBWR    = 4'd8,
        RTYPEEX = 4'd9,
        RTYPEWR = 4'd10,
        BEQEX   = 4'd11,
        JEX     = 4'd12,
        ADDIEX  = 4'd13
    } state_t;

    // ADDIWR lives outside the enum's contiguous run only by name order;
    // the two spare encodings (14 is ADDIWR, 15 is unused) are covered below.
    localparam logic [3:0] ADDIWR_ENC = 4'd14;

    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_controller_alu_decoder.sv
// Maps the controller's aluop and the instruction funct field onto the
// 3-bit ALU control word.
module alu_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int OPBITS = 6
) (
    input  logic [1:0]        aluop_i,
    input  logic [OPBITS-1:0] funct_i,
    output logic [2:0]        alucont_o
);

    // Purely combinational decode; anything unrecognised adds.
    always_comb begin
        alucont_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alucont_o = ALU_ADD;
            ALUOP_SUB: alucont_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  alucont_o = ALU_ADD;
                    FN_SUB:  alucont_o = ALU_SUB;
                    FN_AND:  alucont_o = ALU_AND;
                    FN_OR:   alucont_o = ALU_OR;
                    FN_SLT:  alucont_o = ALU_SLT;
                    default: alucont_o = ALU_ADD;
                endcase
            end
            default:   alucont_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_controller.sv
// Multicycle control FSM for the 8-bit TinyMIPS core. Moore outputs per
// state; pcen additionally folds in the zero flag during a branch.
module mips_controller
    import mips_ctrl_pkg::*;
#(
    parameter int OPBITS = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [OPBITS-1:0] op,
    input  logic [OPBITS-1:0] funct,
    input  logic              zero,
    output logic              memread,
    output logic              memwrite,
    output logic              alusrca,
    output logic [1:0]        alusrcb,
    output logic              memtoreg,
    output logic              iord,
    output logic              pcen,
    output logic              regwrite,
    output logic              regdst,
    output logic [1:0]        pcsource,
    output logic [3:0]        irwrite,
    output logic [2:0]        alucont
);

    // ADDIWR uses the 15th encoding, kept as a raw code next to the enum.
    logic [3:0] state_q, state_d;
    aluop_t     aluop;
    logic       pcwrite;
    logic       branch;
    logic       memwrite_s, regwrite_s;
    logic [3:0] irwrite_s;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) state_q <= FETCH1;
        else       state_q <= state_d;
    end

    // Next-state logic; spare encodings fall back to FETCH1.
    always_comb begin
        state_d = FETCH1;
        case (state_q)
            FETCH1:  state_d = FETCH2;
            FETCH2:  state_d = FETCH3;
            FETCH3:  state_d = FETCH4;
            FETCH4:  state_d = DECODE;
            DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = MEMADR;
                    OP_RTYPE:     state_d = RTYPEEX;
                    OP_BEQ:       state_d = BEQEX;
                    OP_J:         state_d = JEX;
                    OP_ADDI:      state_d = ADDIEX;
                    default:      state_d = FETCH1;
                endcase
            end
            MEMADR:  state_d = (op == OP_SB) ? SBWR : LBRD;
            LBRD:    state_d = LBWR;
            RTYPEEX: state_d = RTYPEWR;
            ADDIEX:  state_d = ADDIWR_ENC;
            default: state_d = FETCH1;
        endcase
    end

    // Moore output decode per state.
    always_comb begin
        memread    = 1'b0;
        memwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        memtoreg   = 1'b0;
        iord       = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite_s = 1'b0;
        regdst     = 1'b0;
        pcsource   = 2'b00;
        irwrite_s  = 4'b0000;
        aluop      = ALUOP_ADD;
        case (state_q)
            FETCH1, FETCH2, FETCH3, FETCH4: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                pcwrite = 1'b1;
                case (state_q)
                    FETCH1:  irwrite_s = 4'b0001;
                    FETCH2:  irwrite_s = 4'b0010;
                    FETCH3:  irwrite_s = 4'b0100;
                    default: irwrite_s = 4'b1000;
                endcase
            end
            DECODE:  alusrcb = 2'b11;
            MEMADR, ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            LBRD: begin
                memread = 1'b1;
                iord    = 1'b1;
            end
            LBWR: begin
                regwrite_s = 1'b1;
                memtoreg   = 1'b1;
            end
            SBWR: begin
                memwrite_s = 1'b1;
                iord       = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            RTYPEWR: begin
                regwrite_s = 1'b1;
                regdst     = 1'b1;
            end
            BEQEX: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                branch   = 1'b1;
                pcsource = 2'b01;
            end
            JEX: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
            ADDIWR_ENC: regwrite_s = 1'b1;
            default: ;
        endcase
    end

    // Architectural side effects are suppressed while reset is held.
    always_comb begin
        memwrite = memwrite_s & ~reset;
        regwrite = regwrite_s & ~reset;
        irwrite  = reset ? 4'b0000 : irwrite_s;
        pcen     = (pcwrite | (branch & zero)) & ~reset;
    end

    alu_decoder #(.OPBITS(OPBITS)) u_alu_decoder (
        .aluop_i   (aluop),
        .funct_i   (funct),
        .alucont_o (alucont)
    );

endmodule

// File: doc/mips_controller.md
Name: mips_controller

Overview:
- Multicycle control FSM for the 8-bit TinyMIPS core.
- Sits directly upstream of the datapath. Consumes instr[31:26] (op), instr[5:0] (funct) and the zero flag. Drives every datapath control input plus the memory read/write strobes.
- Moore FSM; the only Mealy term is pcen during a branch.
- Supports LB, SB, R-type (ADD/SUB/AND/OR/SLT), BEQ, J and ADDI.

Parameters:
- OPBITS, 6, width of the op and funct fields.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op  in  OPBITS  instr[31:26]
- funct  in  OPBITS  instr[5:0]
- zero  in  1  ALU result == 0, from datapath
- memread  out  1  memory read strobe
- memwrite  out  1  memory write strobe
- alusrca  out  1  0 = pc, 1 = A register
- alusrcb  out  2  00 = B reg, 01 = constant 1, 10 = imm, 11 = imm<<2
- memtoreg  out  1  0 = aluout, 1 = MDR
- iord  out  1  0 = pc address, 1 = aluout address
- pcen  out  1  PC load enable
- regwrite  out  1  register file write
- regdst  out  1  0 = rt, 1 = rd
- pcsource  out  2  00 = aluresult, 01 = aluout, 10 = jump target
- irwrite  out  4  IR byte load: [0] -> instr[31:24], [1] -> [23:16], [2] -> [15:8], [3] -> [7:0]
- alucont  out  3  [2] = invert b / carry-in; [1:0]: 00 AND, 01 OR, 10 SUM, 11 SLT

Behaviour:
- Reset: clock is clk; reset is synchronous, active-high.
  - reset high at a rising edge → state = FETCH1.
  - While reset is high, memwrite, regwrite, pcen and irwrite are forced to 0. Other outputs follow the current state.
  - Reset mid-instruction abandons that instruction with no further side effects.
- Unlisted outputs in each state are 0; alucont comes from aluop (default 00).
- State outputs, in order:
  - FETCH1: memread=1, irwrite=0001, alusrcb=01, aluop=00, pcwrite.
  - FETCH2: same outputs, irwrite=0010.
  - FETCH3: same outputs, irwrite=0100.
  - FETCH4: same outputs, irwrite=1000.
  - Each fetch state increments PC by 1; pcsource=00.
  - DECODE: alusrca=0, alusrcb=11, aluop=00; aluout receives the branch target.
  - MEMADR: alusrca=1, alusrcb=10, aluop=00.
  - LBRD: memread=1, iord=1.
  - LBWR: regwrite=1, memtoreg=1, regdst=0.
  - SBWR: memwrite=1, iord=1.
  - RTYPEEX: alusrca=1, alusrcb=00, aluop=10.
  - RTYPEWR: regwrite=1, regdst=1, memtoreg=0.
  - BEQEX: alusrca=1, alusrcb=00, aluop=01, branch=1, pcsource=01.
  - JEX: pcwrite=1, pcsource=10.
  - ADDIEX: alusrca=1, alusrcb=10, aluop=00.
  - ADDIWR: regwrite=1, regdst=0, memtoreg=0.
- pcen = pcwrite | (branch & zero).
- Transitions:
  - FETCH1→FETCH2→FETCH3→FETCH4→DECODE.
  - DECODE by op:
    - LB 100000 or SB 101000 → MEMADR
    - 000000 → RTYPEEX
    - 000100 → BEQEX
    - 000010 → JEX
    - 001000 → ADDIEX
    - any other op → FETCH1 (treated as NOP, no writes)
  - MEMADR: LB → LBRD, SB → SBWR. LBRD → LBWR.
  - RTYPEEX → RTYPEWR; ADDIEX → ADDIWR.
  - LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR → FETCH1.
- Unreachable state encodings → FETCH1 on the next edge.
- Cycles per instruction: LB 8, SB 7, R-type 7, ADDI 7, BEQ 6, J 6.
- aluop → alucont:
  - 00 → 010 (add); 01 → 110 (sub).
  - 10 → by funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.
  - Unknown funct → 010.
  - aluop 11 is unused and decodes to 010.
- op and funct are sampled combinationally. They must be stable from DECODE onward; the IR is not written after FETCH4.

Decomposition:
- Package mips_ctrl_pkg holds:
  - state encodings (4-bit, 14 states)
  - opcode constants (OP_LB, OP_SB, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI)
  - funct constants
  - aluop and alucont encodings
- One sub-module, alu_decoder (aluop[1:0], funct → alucont[2:0]), purely combinational.

Test Plan:
- Reset high 2 cycles, then low → FETCH1 for 4 cycles with irwrite 0001, 0010, 0100, 1000 in sequence; pcen=1 each cycle; memwrite=regwrite=0 throughout reset.
- op=000000, funct=101010 → RTYPEEX alucont=111, alusrca=1, alusrcb=00; next cycle regwrite=1, regdst=1; back to FETCH1 7 cycles after start.
- op=000100 with zero=1 → pcen=1 and pcsource=01 in BEQEX. Repeat with zero=0 → pcen=0. Both return to FETCH1 after 6 cycles.
- op=100000 (LB) → MEMADR alusrcb=10; LBRD memread=1, iord=1; LBWR regwrite=1, memtoreg=1; 8 cycles total. op=101000 → SBWR memwrite=1, 7 cycles.
- Reset asserted in RTYPEEX → no regwrite pulse; next state FETCH1. Unknown op 111111 → DECODE → FETCH1 with no writes.
- op=001000 → ADDIEX alucont=010, alusrcb=10; ADDIWR regwrite=1, regdst=0. op=000010 → JEX pcen=1, pcsource=10.
